output_readout_sequencer: RTL and testbench

Drains the two result memories after a convolution finishes and turns them into one narrow stream for the host. It drives the shared scan address and the output-memory scan mode, captures both 512-bit result words at each address, and serialises them as 64-bit beats over a valid/ready interface. It sits directly downstream of the convolution top level: it starts on `conv_completed` and consumes `output_mem1_scan_out` and `output_mem2_scan_out`.

---
 rtl/readout_pkg.sv | 18 +
 rtl/beat_serializer.sv | 64 ++++++
 rtl/output_readout_sequencer.sv | 96 +++++++++
 tb/tb_output_readout_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/readout_pkg.sv
// Shared definitions for the result-memory readout path: scan-mode encodings,
// the sequencer state type and the result word width.
package readout_pkg;

  localparam int RES_WORD_W = 512;

  localparam logic [1:0] SCAN_IDLE = 2'b00;
  localparam logic [1:0] SCAN_READ = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    SEND,
    FINISH
  } readout_state_t;

endpackage

// File: rtl/beat_serializer.sv
// Holds one captured pair of result words and streams it out as BEAT_W-bit
// beats over valid/ready, memory 1 first, least significant slice first.
module beat_serializer
  import readout_pkg::*;
#(
  parameter int BEAT_W = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_i,
  input  logic                    last_word_i,
  input  logic [2*RES_WORD_W-1:0] word_i,
  output logic [BEAT_W-1:0]       m_data_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic                    m_last_o,
  output logic                    done_o
);

  localparam int NBEATS = (2 * RES_WORD_W) / BEAT_W;
  localparam int CNT_W  = $clog2(NBEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

  logic [NBEATS-1:0][BEAT_W-1:0] word_q;
  logic [CNT_W-1:0]              beat_q;
  logic [CNT_W-1:0]              beat_nxt;
  logic                          last_word_q;
  logic                          fire;

  assign fire     = m_valid_o && m_ready_i;
  assign beat_nxt = beat_q + 1'b1;
  assign done_o   = fire && (beat_q == LAST_BEAT);

  // The capture buffer deliberately survives reset; only control state clears.
  always_ff @(posedge clk) begin
    if (load_i) word_q <= word_i;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_q      <= '0;
      last_word_q <= 1'b0;
      m_data_o    <= '0;
      m_valid_o   <= 1'b0;
      m_last_o    <= 1'b0;
    end else if (load_i) begin
      beat_q      <= '0;
      last_word_q <= last_word_i;
      m_data_o    <= word_i[BEAT_W-1:0];
      m_valid_o   <= 1'b1;
      m_last_o    <= last_word_i && (LAST_BEAT == '0);
    end else if (fire) begin
      if (beat_q == LAST_BEAT) begin
        m_valid_o <= 1'b0;
        m_last_o  <= 1'b0;
      end else begin
        beat_q   <= beat_nxt;
        m_data_o <= word_q[beat_nxt];
        m_last_o <= last_word_q && (beat_nxt == LAST_BEAT);
      end
    end
  end

endmodule

// File: rtl/output_readout_sequencer.sv
// Walks the shared scan address from 0 to the latched last address, captures
// both result words per address and hands them to the beat serializer.
module output_readout_sequencer
  import readout_pkg::*;
#(
  parameter int BEAT_W = 64,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [7:0]            last_addr_i,
  output logic [1:0]            scan_mode_o,
  output logic [7:0]            scan_addr_o,
  input  logic [RES_WORD_W-1:0] mem1_data_i,
  input  logic [RES_WORD_W-1:0] mem2_data_i,
  output logic [BEAT_W-1:0]     m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  m_last_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  readout_state_t state_q, state_d;
  logic [7:0]     addr_q;
  logic [7:0]     last_addr_q;
  logic [1:0]     lat_q;
  logic           load;
  logic           ser_done;
  logic           last_word;

  assign last_word   = (addr_q == last_addr_q);
  assign scan_addr_o = addr_q;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE:    if (start_i) state_d = ADDR;
      ADDR:    state_d = WAIT;
      WAIT: begin
        if (lat_q == LAT_LAST) begin
          load    = 1'b1;
          state_d = SEND;
        end
      end
      SEND:    if (ser_done) state_d = last_word ? FINISH : ADDR;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      last_addr_q <= '0;
      lat_q       <= '0;
      scan_mode_o <= SCAN_IDLE;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start_i) begin
        last_addr_q <= last_addr_i;
        addr_q      <= '0;
      end else if (state_q == SEND && ser_done && !last_word) begin
        addr_q <= addr_q + 8'd1;
      end
      lat_q       <= (state_q == WAIT) ? lat_q + 2'd1 : 2'd0;
      scan_mode_o <= (state_d == ADDR || state_d == WAIT) ? SCAN_READ : SCAN_IDLE;
      busy_o      <= (state_d == ADDR || state_d == WAIT || state_d == SEND);
      done_o      <= (state_d == FINISH);
    end
  end

  beat_serializer #(
    .BEAT_W(BEAT_W)
  ) u_beat_serializer (
    .clk         (clk),
    .reset       (reset),
    .load_i      (load),
    .last_word_i (last_word),
    .word_i      ({mem2_data_i, mem1_data_i}),
    .m_data_o    (m_data_o),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .m_last_o    (m_last_o),
    .done_o      (ser_done)
  );

endmodule

// File: tb/tb_output_readout_sequencer.sv
// Scoreboard bench: expected beats are queued at start, a negedge monitor pops
// and compares each accepted beat; a second instance checks RD_LAT=3 capture timing.
module tb_output_readout_sequencer;
  import readout_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Primary instance, RD_LAT = 1
  logic         startIn;
  logic [7:0]   lastAddrIn;
  logic [1:0]   scanMode;
  logic [7:0]   scanAddr;
  logic [511:0] mem1Data, mem2Data;
  logic [63:0]  mData;
  logic         mValid, mReady, mLast, busy, done;

  output_readout_sequencer #(.BEAT_W(64), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset), .start_i(startIn), .last_addr_i(lastAddrIn),
    .scan_mode_o(scanMode), .scan_addr_o(scanAddr),
    .mem1_data_i(mem1Data), .mem2_data_i(mem2Data),
    .m_data_o(mData), .m_valid_o(mValid), .m_ready_i(mReady), .m_last_o(mLast),
    .busy_o(busy), .done_o(done)
  );

  // Latency instance, RD_LAT = 3, memory data changes every cycle
  logic         start3;
  logic [1:0]   scanMode3;
  logic [7:0]   scanAddr3;
  logic [511:0] mem3a, mem3b;
  logic [63:0]  mData3;
  logic         mValid3, mLast3, busy3, done3;

  output_readout_sequencer #(.BEAT_W(64), .RD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .start_i(start3), .last_addr_i(8'd0),
    .scan_mode_o(scanMode3), .scan_addr_o(scanAddr3),
    .mem1_data_i(mem3a), .mem2_data_i(mem3b),
    .m_data_o(mData3), .m_valid_o(mValid3), .m_ready_i(1'b1), .m_last_o(mLast3),
    .busy_o(busy3), .done_o(done3)
  );

  function automatic logic [63:0] beatVal(input logic [7:0] a, input int k);
    return {24'h5A5A5A, a, 24'h000000, 8'(k)};
  endfunction

  // One-cycle-latency memory; returns all ones when not in read mode
  always @(posedge clk) begin
    for (int j = 0; j < 8; j++) begin
      mem1Data[j*64 +: 64] <= (scanMode == 2'b10) ? beatVal(scanAddr, j)     : '1;
      mem2Data[j*64 +: 64] <= (scanMode == 2'b10) ? beatVal(scanAddr, j + 8) : '1;
    end
  end

  always_comb begin
    mem3a = '0;
    mem3b = '0;
    for (int j = 0; j < 8; j++) begin
      mem3a[j*64 +: 64] = {32'(cycle), 32'(j)};
      mem3b[j*64 +: 64] = {32'(cycle), 32'(j + 8)};
    end
  end

  int testsRun = 0;
  int testsFailed = 0;
  logic [64:0] expQ[$];
  int startCycle, firstValidCycle, acceptedCount;
  bit toggleReady = 1'b0;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (toggleReady) mReady = ~mReady;
  end

  // Monitor: compares every accepted beat and checks stability while stalled
  logic        prevStall = 1'b0;
  logic [64:0] prevBeat;
  always @(negedge clk) begin
    if (reset) begin
      if (prevStall) checkOutput("stallHold", {mValid, mLast, mData}, {1'b1, prevBeat});
      if (mValid && mReady) begin
        if (expQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL extraBeat: got beat %0h, expected no beat", {mLast, mData});
        end else begin
          checkOutput("beat", {mLast, mData}, expQ.pop_front());
        end
        acceptedCount++;
      end
      if (mValid && firstValidCycle < 0) firstValidCycle = cycle;
      prevStall = mValid && !mReady;
      prevBeat  = {mLast, mData};
    end else begin
      prevStall = 1'b0;
    end
  end

  task automatic applyStimulus(input logic [7:0] lastAddr);
    for (int a = 0; a <= int'(lastAddr); a++)
      for (int k = 0; k < 16; k++)
        expQ.push_back({(a == int'(lastAddr) && k == 15), beatVal(8'(a), k)});
    @(posedge clk); #1;
    startIn = 1'b1;
    lastAddrIn = lastAddr;
    startCycle = cycle;
    firstValidCycle = -1;
    acceptedCount = 0;
    @(posedge clk); #1;
    startIn = 1'b0;
    checkOutput("busyAtS1", busy, 1'b1);
    checkOutput("addrAtS1", scanAddr, 8'd0);
    checkOutput("modeAtS1", scanMode, 2'b10);
  endtask

  task automatic waitDone(input int budget, input string name);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, done, 1'b1);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput(name, {scanMode, scanAddr, mData, mValid, mLast, busy, done}, '0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s3, n;
    reset = 1'b0; startIn = 1'b0; lastAddrIn = '0; mReady = 1'b1; start3 = 1'b0;
    firstValidCycle = -1; acceptedCount = 0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstScanMode", scanMode, 2'b00);
    checkOutput("rstScanAddr", scanAddr, 8'd0);
    checkOutput("rstData", mData, 64'd0);
    checkOutput("rstValid", mValid, 1'b0);
    checkOutput("rstLast", mLast, 1'b0);
    checkOutput("rstBusy", busy, 1'b0);
    checkOutput("rstDone", done, 1'b0);
    reset = 1'b1;

    // Single address, ready high; a start coinciding with done must be ignored
    applyStimulus(8'd0);
    waitDone(100, "singleDone");
    checkOutput("singleFirstValid", firstValidCycle, startCycle + 3);
    checkOutput("singleDoneCycle", cycle, startCycle + 19);
    checkOutput("singleBusyAtDone", busy, 1'b0);
    startIn = 1'b1;
    lastAddrIn = 8'd0;
    @(posedge clk); #1;
    startIn = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("startOnDoneBusy", busy, 1'b0);
    checkOutput("startOnDoneValid", mValid, 1'b0);
    checkOutput("singleQueue", expQ.size(), 0);

    // Backpressure with a start pulse mid-drain
    toggleReady = 1'b1;
    applyStimulus(8'd2);
    repeat (10) @(posedge clk);
    #1;
    startIn = 1'b1;
    lastAddrIn = 8'd0;
    @(posedge clk); #1;
    startIn = 1'b0;
    waitDone(400, "bpDone");
    toggleReady = 1'b0;
    mReady = 1'b1;
    checkOutput("bpCount", acceptedCount, 48);
    checkOutput("bpQueue", expQ.size(), 0);
    expQ.delete();

    // Full 256-address drain
    applyStimulus(8'hFF);
    waitDone(5000, "fullDone");
    checkOutput("fullCount", acceptedCount, 4096);
    checkOutput("fullFinalAddr", scanAddr, 8'hFF);
    checkOutput("fullQueue", expQ.size(), 0);
    expQ.delete();

    // Reset during beat 5 of address 1, then a fresh drain
    applyStimulus(8'd3);
    n = 0;
    while (acceptedCount < 21 && n < 200) begin
      @(posedge clk);
      n++;
    end
    checkOutput("reachBeat21", acceptedCount, 21);
    #2;
    reset = 1'b0;
    expQ.delete();
    @(negedge clk);
    checkAllZero("midResetOutputs");
    @(posedge clk); #1;
    reset = 1'b1;
    applyStimulus(8'd0);
    waitDone(100, "restartDone");
    checkOutput("restartFirstValid", firstValidCycle, startCycle + 3);
    checkOutput("restartQueue", expQ.size(), 0);

    // Read latency 3: capture must use the data present 3 cycles after the address
    @(posedge clk); #1;
    start3 = 1'b1;
    s3 = cycle;
    @(posedge clk); #1;
    start3 = 1'b0;
    n = 0;
    while (!mValid3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("lat3FirstValid", cycle, s3 + 5);
    checkOutput("lat3Beat0", mData3, {32'(s3 + 4), 32'd0});
    @(negedge clk);
    checkOutput("lat3Beat1", mData3, {32'(s3 + 4), 32'd1});
    n = 0;
    while (!done3 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("lat3Done", done3, 1'b1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
